sseg_frame_decoder: RTL and testbench
=====================================

# sseg_frame_decoder

Passive monitor on the multiplexed seven-segment bus (`an`, `sseg`) driven by the display scan logic. It de-multiplexes the four scanned digits, decodes each segment pattern back to a glyph code, and publishes a coherent four-digit frame. It is used on-board for self-check and readback of timer results, and in benches as the scoreboard front end for display-producing blocks.

## Interface
- SETTLE, 4: consecutive cycles a valid `an` value must be held before its digit is captured (range 2–255).
- TO_W, 20: timeout counter width; `stale` asserts after 2^TO_W − 1 cycles without a capture.
- clk  in  1  system clock; `an`/`sseg` are synchronous to it.
- rst  in  1  reset rst, synchronous, active-high.
- an  in  8  anode enables, active-low; only `an[3:0]` carry digits.
- sseg  in  8  segments, active-low; bit 7 = dp, bits 6:0 = g..a.
- dig0, dig1, dig2, dig3  out  4 each  decoded glyph codes of the last published frame.
- dp  out  4  decoded decimal points, active-high; bit i belongs to digit i.
- frame_stb  out  1  one-cycle pulse when a new frame is published.
- stale  out  1  high while no capture has occurred for the timeout period.
- err_cnt  out  8  saturating count of illegal `an` patterns.

## Operation
- Input stage: `an` and `sseg` are registered once into `an_q` and `sseg_q`. All logic uses the registered copies.
- Valid `an_q`: `an_q[7:4]` = 4'hF and exactly one zero in `an_q[3:0]`. All-ones is idle: legal, ignored, and not an error.
- An illegal pattern is any other value. It increments `err_cnt`, which saturates at 255, and forces the FSM to SEEK.
- Glyph decode uses `sseg_q[6:0]`:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - 0x7F→0xA (blank), 0x09→0xB ("H").
  - Every other pattern →0xF (unknown).
  - The dp bit is `~sseg_q[7]`.
- FSM states:
  - SEEK: wait for a valid `an_q`, then load the settle counter with 1 and go to SETTLING.
  - SETTLING: while `an_q` is unchanged, increment the counter. When it reaches SETTLE, capture and go to HELD. If `an_q` changes to another valid value, reload the counter with 1 and stay. If it goes idle or illegal, go to SEEK.
  - HELD: wait for `an_q` to change. On a valid new value, reload the counter with 1 and go to SETTLING. On idle or illegal, go to SEEK. A digit is captured only once per anode dwell.
- Capture writes the decoded code and dp into the shadow slot of the active digit and sets that bit in `cap_mask`.
  - A repeated capture of the same digit before the frame completes overwrites the shadow slot. The mask is unchanged.
- Publish: when a capture makes `cap_mask` = 4'hF, the next cycle copies all four shadow slots to `dig*`/`dp`, pulses `frame_stb`, and clears `cap_mask`. Outputs change only on publish, so each frame is atomic.
- Timeout: the counter clears on every capture and saturates at all-ones. `stale` = counter at all-ones. `stale` falls the cycle after the next capture.

## Timing
- Reset values:
  - FSM = SEEK, `cap_mask` = 0, shadow slots = 0xA.
  - `dig0`–`dig3` = 4'hA, `dp` = 0, `frame_stb` = 0, `stale` = 0, `err_cnt` = 0, timeout counter = 0.
  - `an_q` = 8'hFF, `sseg_q` = 8'hFF.
- Capture latency: an `an` value first presented at cycle t (pin) is captured at the rising edge ending cycle t+SETTLE. The data captured is `sseg_q` at that cycle, i.e. pin `sseg` at cycle t+SETTLE−1.
- Publish: `dig*`/`dp` update and `frame_stb` pulses one cycle after the completing capture.
- Dwell rule: dwells shorter than SETTLE cycles never capture. A `sseg` change mid-dwell after the capture is ignored.
- Simultaneous events: an illegal `an` has priority over capture in the same cycle. Capture and timeout saturation in the same cycle resolve as capture: the counter clears and `stale` stays 0.
- `rst` asserted mid-frame discards partial shadow contents and `cap_mask`. Published outputs return to their reset values.
- Throughput: one frame per four dwells; no backpressure.

## Test plan
- Scan "12.34" (d3..d0) with dwell 8, SETTLE=4 → exactly one `frame_stb` after the 4th dwell. Outputs: `dig3..0` = 1,2,3,4; `dp` = 4'b0100.
- Digits 0x7F/0x7F/0x09/0x79 → `dig3..0` = A,A,B,1. Digit pattern 0x55 → 0xF.
- Dwell 3 cycles with SETTLE=4 → no capture and no `frame_stb`. A later 4-cycle dwell captures normally.
- `an` = 8'b11110011 for 1 cycle → `err_cnt` +1 and the FSM returns to SEEK. Drive 300 illegal cycles → `err_cnt` stays 255.
- TO_W=4 and `an` held 8'hFF → `stale` = 1 after 15 cycles. The next valid capture → `stale` = 0.
- Assert `rst` after 2 of 4 digits are captured → outputs read A/0/0. The next full scan publishes only that scan's four digits.

Source files
------------

// File: rtl/sseg_frame_decoder.sv
// Passive seven-segment bus monitor: de-multiplexes the four scanned digits,
// decodes glyphs and publishes each complete four-digit frame atomically.
module sseg_frame_decoder #(
    parameter int SETTLE = 4,
    parameter int TO_W   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] an,
    input  logic [7:0] sseg,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] dp,
    output logic       frame_stb,
    output logic       stale,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        SEEK     = 2'd0,
        SETTLING = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t          state_q, state_d;
    logic [7:0]      an_q, an_d;
    logic [7:0]      sseg_q, sseg_d;
    logic [7:0]      an_prev_q, an_prev_d;
    logic [7:0]      set_cnt_q, set_cnt_d;
    logic [3:0]      cap_mask_q, cap_mask_d;
    logic [15:0]     shd_q, shd_d;
    logic [3:0]      shd_dp_q, shd_dp_d;
    logic [15:0]     dig_q, dig_d;
    logic [3:0]      dp_q, dp_d;
    logic            frame_stb_q, frame_stb_d;
    logic [7:0]      err_q, err_d;
    logic [TO_W-1:0] to_q, to_d;

    logic       an_idle;
    logic       an_valid;
    logic       an_bad;
    logic       an_chg;
    logic       settled;
    logic       capture;
    logic       publish;
    logic [1:0] cap_idx;
    logic [3:0] glyph;

    assign an_idle  = (an_q == 8'hFF);
    assign an_valid = (an_q[7:4] == 4'hF) && $onehot(~an_q[3:0]);
    assign an_bad   = !an_valid && !an_idle;
    assign an_chg   = (an_q != an_prev_q);
    assign settled  = (set_cnt_q == SETTLE_LAST);
    assign publish  = (cap_mask_q == 4'hF);

    always_comb begin
        cap_idx = 2'd0;
        unique case (an_q[3:0])
            4'b1110: cap_idx = 2'd0;
            4'b1101: cap_idx = 2'd1;
            4'b1011: cap_idx = 2'd2;
            4'b0111: cap_idx = 2'd3;
            default: cap_idx = 2'd0;
        endcase
    end

    always_comb begin
        glyph = 4'hF;
        unique case (sseg_q[6:0])
            7'h40:   glyph = 4'h0;
            7'h79:   glyph = 4'h1;
            7'h24:   glyph = 4'h2;
            7'h30:   glyph = 4'h3;
            7'h19:   glyph = 4'h4;
            7'h12:   glyph = 4'h5;
            7'h02:   glyph = 4'h6;
            7'h78:   glyph = 4'h7;
            7'h00:   glyph = 4'h8;
            7'h10:   glyph = 4'h9;
            7'h7F:   glyph = 4'hA;
            7'h09:   glyph = 4'hB;
            default: glyph = 4'hF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= SEEK;
        else     state_q <= state_d;
    end

    // Idle or illegal anodes always fall back to SEEK, so they win over capture.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEEK: begin
                if (an_valid) state_d = SETTLING;
            end
            SETTLING: begin
                if (!an_valid)             state_d = SEEK;
                else if (!an_chg && settled) state_d = HELD;
            end
            HELD: begin
                if (!an_valid)   state_d = SEEK;
                else if (an_chg) state_d = SETTLING;
            end
            default: state_d = SEEK;
        endcase
    end

    always_comb begin
        set_cnt_d = set_cnt_q;
        capture   = 1'b0;
        case (state_q)
            SEEK: begin
                if (an_valid) set_cnt_d = 8'd1;
            end
            SETTLING: begin
                if (an_valid) begin
                    if (an_chg) begin
                        set_cnt_d = 8'd1;
                    end else begin
                        set_cnt_d = set_cnt_q + 8'd1;
                        capture   = settled;
                    end
                end
            end
            HELD: begin
                if (an_valid && an_chg) set_cnt_d = 8'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        an_d        = an;
        sseg_d      = sseg;
        an_prev_d   = an_q;
        shd_d       = shd_q;
        shd_dp_d    = shd_dp_q;
        cap_mask_d  = publish ? 4'h0 : cap_mask_q;
        if (capture) begin
            shd_d[{cap_idx, 2'b00} +: 4] = glyph;
            shd_dp_d[cap_idx]            = ~sseg_q[7];
            cap_mask_d[cap_idx]          = 1'b1;
        end
        dig_d       = publish ? shd_q : dig_q;
        dp_d        = publish ? shd_dp_q : dp_q;
        frame_stb_d = publish;
        err_d       = (an_bad && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        to_d        = capture ? '0 : ((&to_q) ? to_q : to_q + TO_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q        <= 8'hFF;
            sseg_q      <= 8'hFF;
            an_prev_q   <= 8'hFF;
            set_cnt_q   <= 8'd0;
            cap_mask_q  <= 4'h0;
            shd_q       <= 16'hAAAA;
            shd_dp_q    <= 4'h0;
            dig_q       <= 16'hAAAA;
            dp_q        <= 4'h0;
            frame_stb_q <= 1'b0;
            err_q       <= 8'd0;
            to_q        <= '0;
        end else begin
            an_q        <= an_d;
            sseg_q      <= sseg_d;
            an_prev_q   <= an_prev_d;
            set_cnt_q   <= set_cnt_d;
            cap_mask_q  <= cap_mask_d;
            shd_q       <= shd_d;
            shd_dp_q    <= shd_dp_d;
            dig_q       <= dig_d;
            dp_q        <= dp_d;
            frame_stb_q <= frame_stb_d;
            err_q       <= err_d;
            to_q        <= to_d;
        end
    end

    assign dig0      = dig_q[3:0];
    assign dig1      = dig_q[7:4];
    assign dig2      = dig_q[11:8];
    assign dig3      = dig_q[15:12];
    assign dp        = dp_q;
    assign frame_stb = frame_stb_q;
    assign stale     = &to_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_sseg_frame_decoder.sv
// Directed bench for sseg_frame_decoder: scans frames on the an/sseg bus
// and checks published digits, strobes, error count and stale flag.
module tb_sseg_frame_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] an;
    logic [7:0] sseg;
    logic [3:0] dig0, dig1, dig2, dig3, dp;
    logic       frame_stb, stale;
    logic [7:0] err_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int stb_cnt = 0;

    sseg_frame_decoder #(.SETTLE(4), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .an(an), .sseg(sseg),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .dp(dp), .frame_stb(frame_stb), .stale(stale),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_stb === 1'b1) stb_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dwell(input int idx, input logic [7:0] seg, input int n);
        logic [3:0] one;
        one  = 4'b0001;
        an   = {4'hF, ~(one << idx)};
        sseg = seg;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        an   = 8'hFF;
        sseg = 8'hFF;
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst  = 1'b1;
        an   = 8'hFF;
        sseg = 8'hFF;
        tick();
        tick();
        check("rst_dig", {dig3, dig2, dig1, dig0}, 16'hAAAA);
        check("rst_dp", dp, 4'h0);
        check("rst_stb", frame_stb, 1'b0);
        check("rst_stale", stale, 1'b0);
        check("rst_err", err_cnt, 8'd0);
        rst = 1'b0;

        repeat (14) tick();
        check("stale_14", stale, 1'b0);
        tick();
        check("stale_15", stale, 1'b1);
        dwell(0, 8'hC0, 4);
        check("stale_hold", stale, 1'b1);
        idle(1);
        check("stale_clear", stale, 1'b0);

        dwell(0, 8'h99, 8);
        dwell(1, 8'hB0, 8);
        dwell(2, 8'h24, 8);
        check("f1_early", stb_cnt, 0);
        dwell(3, 8'hF9, 8);
        idle(3);
        check("f1_stb", stb_cnt, 1);
        check("f1_dig", {dig3, dig2, dig1, dig0}, 16'h1234);
        check("f1_dp", dp, 4'b0100);

        dwell(0, 8'hF9, 8);
        dwell(1, 8'h89, 8);
        dwell(2, 8'hFF, 8);
        dwell(3, 8'hFF, 8);
        idle(3);
        check("f2_stb", stb_cnt, 2);
        check("f2_dig", {dig3, dig2, dig1, dig0}, 16'hAAB1);
        check("f2_dp", dp, 4'b0000);

        dwell(0, 8'hD5, 8);
        dwell(1, 8'h40, 8);
        dwell(2, 8'h82, 8);
        dwell(3, 8'h78, 8);
        idle(3);
        check("f3_stb", stb_cnt, 3);
        check("f3_dig", {dig3, dig2, dig1, dig0}, 16'h760F);
        check("f3_dp", dp, 4'b1010);

        dwell(0, 8'h92, 4);
        dwell(0, 8'h80, 4);
        dwell(1, 8'h80, 8);
        dwell(2, 8'h90, 8);
        dwell(3, 8'hF8, 3);
        idle(5);
        check("f4_short", stb_cnt, 3);
        dwell(3, 8'h90, 4);
        idle(3);
        check("f4_stb", stb_cnt, 4);
        check("f4_dig", {dig3, dig2, dig1, dig0}, 16'h9985);
        check("f4_dp", dp, 4'b0000);

        dwell(1, 8'hC0, 8);
        dwell(2, 8'hF9, 8);
        dwell(3, 8'hA4, 8);
        dwell(0, 8'hB0, 3);
        an = 8'b11110011;
        tick();
        dwell(0, 8'hB0, 3);
        idle(4);
        check("f5_nocap", stb_cnt, 4);
        check("err_one", err_cnt, 8'd1);
        dwell(0, 8'hB0, 8);
        idle(3);
        check("f5_stb", stb_cnt, 5);
        check("f5_dig", {dig3, dig2, dig1, dig0}, 16'h2103);

        an = 8'h7E;
        repeat (253) tick();
        idle(2);
        check("err_254", err_cnt, 8'd254);
        an = 8'b11110011;
        repeat (47) tick();
        idle(2);
        check("err_sat", err_cnt, 8'd255);
        check("err_nostb", stb_cnt, 5);

        dwell(0, 8'hF9, 8);
        dwell(1, 8'hA4, 8);
        idle(2);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst2_dig", {dig3, dig2, dig1, dig0}, 16'hAAAA);
        check("rst2_dp", dp, 4'h0);
        check("rst2_err", err_cnt, 8'd0);
        check("rst2_stale", stale, 1'b0);
        dwell(2, 8'h99, 8);
        dwell(3, 8'h92, 8);
        idle(3);
        check("rst2_part", stb_cnt, 5);
        dwell(0, 8'h82, 8);
        dwell(1, 8'hF8, 8);
        idle(3);
        check("f6_stb", stb_cnt, 6);
        check("f6_dig", {dig3, dig2, dig1, dig0}, 16'h5476);
        check("f6_dp", dp, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
